// File: rtl/parking_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : parking_gate_ctrl
//  Description : Multi-slot parking gate controller. Authenticates a driver
//                token, then admits a car into a slot (recording entry time)
//                or releases it (reporting parked duration). Repeated token
//                failures trigger a timed lockout.
//                Optional macro PARKING_FEE_EN adds a saturating fee output
//                (duration x RATE); without it fee is constant 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module parking_gate_ctrl #(
    parameter int N_SLOTS     = 4,
    parameter int TOKEN_W     = 3,
    parameter int TIME_W      = 8,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 16,
    parameter int RATE        = 5,
    localparam int SLOT_W     = $clog2(N_SLOTS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                request,
    input  logic                mode,
    input  logic [SLOT_W-1:0]   slot_id,
    input  logic                confirm,
    input  logic [TOKEN_W-1:0]  user_token,
    input  logic [TOKEN_W-1:0]  system_token,
    input  logic [TIME_W-1:0]   time_now,
    output logic                grant,
    output logic                deny,
    output logic                locked,
    output logic [N_SLOTS-1:0]  occupied,
    output logic [TIME_W-1:0]   duration,
    output logic                duration_valid,
    output logic [TIME_W+7:0]   fee,
    output logic [2:0]          state_o
);

    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int FEE_W  = TIME_W + 8;
    localparam logic [FAIL_W-1:0] MAX_TRIES_C = FAIL_W'(MAX_TRIES);
    localparam logic [LOCK_W-1:0] LOCK_LAST   = LOCK_W'(LOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_AUTH   = 3'd1,
        S_COMMIT = 3'd2,
        S_GRANT  = 3'd3,
        S_DENY   = 3'd4,
        S_LOCK   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic                grant_q, deny_q, locked_q;
    logic                mode_q;
    logic [SLOT_W-1:0]   slot_q;
    logic [N_SLOTS-1:0]  occupied_q;
    logic [TIME_W-1:0]   entry_time_q [N_SLOTS];
    logic [TIME_W-1:0]   duration_q;
    logic                dur_valid_q;

    logic                w_slot_ok;
    logic                w_tok_ok;
    logic                w_slot_busy;
    logic [TIME_W-1:0]   w_dur;
    logic                w_exit_commit;

    assign w_slot_ok     = (32'(slot_id) < N_SLOTS);
    assign w_tok_ok      = (user_token == system_token);
    assign w_slot_busy   = occupied_q[slot_q];
    // Modular subtraction gives the right answer across a time-stamp wrap.
    assign w_dur         = time_now - entry_time_q[slot_q];
    assign w_exit_commit = (state_q == S_COMMIT) && mode_q;

    // Next-state logic, failure counter and lockout timer.
    always_comb begin
        state_d    = state_q;
        fail_d     = fail_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (request) state_d = w_slot_ok ? S_AUTH : S_DENY;
            end
            S_AUTH: begin
                if (!request) begin
                    state_d = S_IDLE;
                end else if (confirm) begin
                    if (w_tok_ok) begin
                        // Entry needs a free slot, exit needs an occupied one.
                        state_d = (mode_q == w_slot_busy) ? S_COMMIT : S_DENY;
                    end else begin
                        fail_d = fail_q + FAIL_W'(1);
                        if (fail_d == MAX_TRIES_C) begin
                            state_d    = S_LOCK;
                            lock_cnt_d = '0;
                        end else begin
                            state_d = S_DENY;
                        end
                    end
                end
            end
            S_COMMIT: begin
                fail_d  = '0;
                state_d = S_GRANT;
            end
            S_GRANT, S_DENY: begin
                if (!request) state_d = S_IDLE;
            end
            S_LOCK: begin
                if (lock_cnt_q == LOCK_LAST) begin
                    fail_d     = '0;
                    lock_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register and status flags registered on entry to each state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            fail_q     <= '0;
            lock_cnt_q <= '0;
            grant_q    <= 1'b0;
            deny_q     <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fail_q     <= fail_d;
            lock_cnt_q <= lock_cnt_d;
            grant_q    <= (state_d == S_GRANT);
            deny_q     <= (state_d == S_DENY);
            locked_q   <= (state_d == S_LOCK);
        end
    end

    // Request latching plus slot occupancy, entry times and exit duration.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_q      <= 1'b0;
            slot_q      <= '0;
            occupied_q  <= '0;
            duration_q  <= '0;
            dur_valid_q <= 1'b0;
            for (int i = 0; i < N_SLOTS; i++) entry_time_q[i] <= '0;
        end else begin
            dur_valid_q <= 1'b0;
            if ((state_q == S_IDLE) && request) begin
                mode_q <= mode;
                slot_q <= slot_id;
            end
            if (state_q == S_COMMIT) begin
                if (!mode_q) begin
                    occupied_q[slot_q]   <= 1'b1;
                    entry_time_q[slot_q] <= time_now;
                end else begin
                    occupied_q[slot_q] <= 1'b0;
                    duration_q         <= w_dur;
                    dur_valid_q        <= 1'b1;
                end
            end
        end
    end

`ifdef PARKING_FEE_EN
    localparam int PROD_W = TIME_W + 32;
    logic [PROD_W-1:0] w_prod;
    logic [FEE_W-1:0]  w_fee_sat;
    logic [FEE_W-1:0]  fee_q;

    assign w_prod    = PROD_W'(w_dur) * PROD_W'(RATE);
    assign w_fee_sat = (|w_prod[PROD_W-1:FEE_W]) ? '1 : w_prod[FEE_W-1:0];

    // Fee register, updated alongside duration on every exit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fee_q <= '0;
        end else if (w_exit_commit) begin
            fee_q <= w_fee_sat;
        end
    end

    assign fee = fee_q;
`else
    logic        w_unused_exit;
    logic [31:0] w_unused_rate;
    assign w_unused_exit = w_exit_commit;
    assign w_unused_rate = RATE;
    assign fee           = '0;
`endif

    assign grant          = grant_q;
    assign deny           = deny_q;
    assign locked         = locked_q;
    assign occupied       = occupied_q;
    assign duration       = duration_q;
    assign duration_valid = dur_valid_q;
    assign state_o        = state_q;

endmodule
`default_nettype wire
